// File: rtl/subbytes_sched.sv
// subbytes_sched: byte-serial AES SubBytes sequencer sharing one
// Canright S-box core, plain or first-order masked.
package subbytes_sched_pkg;

  typedef enum logic [1:0] {
    FILL,
    RUN_REQ,
    RUN_WAIT,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] mask;
  } entry_t;

  typedef struct packed {
    logic       masked;
    logic [7:0] data;
    logic [7:0] mask_in;
    logic [7:0] mask_out;
    logic [7:0] rnd;
  } sb_op_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]}
         ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

module subbytes_sched
  import subbytes_sched_pkg::*;
#(
  parameter int          N_BYTES   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       masked_en,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic [7:0] in_mask,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic [7:0] out_mask,
  output logic       busy,
  output logic       done,
  output logic       sb_req,
  output logic       sb_masked,
  output logic [7:0] sb_data,
  output logic [7:0] sb_mask_in,
  output logic [7:0] sb_mask_out,
  output logic [7:0] sb_rand,
  input  logic       sb_ack,
  input  logic [7:0] sb_result
);

  localparam int IW =
    (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(N_BYTES - 1);

  state_e        state_q;
  state_e        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  entry_t        mem_q [N_BYTES];
  entry_t        cur;
  logic          mode_q;
  logic [15:0]   lfsr_q;
  sb_op_t        op_q;
  sb_op_t        req_op;
  sb_op_t        sb_op;
  logic          idx_last;
  logic          in_fire;
  logic          out_fire;
  logic          ack_fire;

  assign cur      = mem_q[idx_q];
  assign idx_last = (idx_q == LAST);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign ack_fire = (state_q == RUN_WAIT)
                  & sb_ack & ~flush;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = FILL;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_fire) begin
            if (idx_last) begin
              state_d = RUN_REQ;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        RUN_REQ: state_d = RUN_WAIT;
        RUN_WAIT: begin
          if (sb_ack) begin
            if (idx_last) begin
              state_d = DRAIN;
              idx_d   = '0;
            end else begin
              state_d = RUN_REQ;
              idx_d   = idx_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (idx_last) begin
              state_d = FILL;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = FILL;
          idx_d   = '0;
        end
      endcase
    end
  end

  // operands for the request issued this cycle
  always_comb begin
    req_op        = '0;
    req_op.masked = mode_q;
    if (mode_q) begin
      req_op.data     = cur.data;
      req_op.mask_in  = cur.mask;
      req_op.mask_out = lfsr_q[7:0];
      req_op.rnd      = lfsr_q[15:8];
    end else begin
      req_op.data = cur.data ^ cur.mask;
    end
  end

  // outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    sb_req    = 1'b0;
    sb_op     = '0;
    unique case (1'b1)
      (state_q == FILL):
        in_ready = rst_n & ~flush;
      (state_q == RUN_REQ): begin
        busy   = 1'b1;
        sb_req = ~flush;
        sb_op  = req_op;
      end
      (state_q == RUN_WAIT): begin
        busy  = 1'b1;
        sb_op = op_q;
      end
      (state_q == DRAIN):
        out_valid = ~flush;
      default: ;
    endcase
    done     = out_valid & out_ready & idx_last;
    out_byte = (state_q == DRAIN) ? cur.data : '0;
    out_mask = (state_q == DRAIN) ? cur.mask : '0;
  end

  assign sb_masked   = sb_op.masked;
  assign sb_data     = sb_op.data;
  assign sb_mask_in  = sb_op.mask_in;
  assign sb_mask_out = sb_op.mask_out;
  assign sb_rand     = sb_op.rnd;

  // operands are frozen for the whole wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      op_q   <= '0;
    end else if (!flush) begin
      if (in_fire && idx_last)
        mode_q <= masked_en;
      if (state_q == RUN_REQ) begin
        op_q <= req_op;
        if (mode_q)
          lfsr_q <= lfsr_step(lfsr_q);
      end
    end
  end

  // results overwrite their source byte in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BYTES; i++)
        mem_q[i] <= '0;
    end else if (in_fire) begin
      mem_q[idx_q] <= '{data: in_byte,
                        mask: in_mask};
    end else if (ack_fire) begin
      mem_q[idx_q] <= '{data: sb_result,
                        mask: op_q.mask_out};
    end
  end

endmodule

// File: tb/tb_subbytes_sched.sv
// tb_subbytes_sched: directed vector bench with a behavioural
// S-box core model for subbytes_sched.
module tb_subbytes_sched;

  localparam int N = 16;

  typedef struct {
    logic [7:0] in_b;
    logic [7:0] in_m;
    logic [7:0] exp_t;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       masked_en;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic [7:0] in_mask;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic [7:0] out_mask;
  logic       busy;
  logic       done;
  logic       sb_req;
  logic       sb_masked;
  logic [7:0] sb_data;
  logic [7:0] sb_mask_in;
  logic [7:0] sb_mask_out;
  logic [7:0] sb_rand;
  logic       sb_ack;
  logic [7:0] sb_result;

  logic       core_ack;
  logic [7:0] core_res;
  logic       spur_ack;
  logic [7:0] spur_res;

  assign sb_ack    = core_ack | spur_ack;
  assign sb_result = spur_ack ? spur_res : core_res;

  subbytes_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .masked_en  (masked_en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_mask   (out_mask),
    .busy       (busy),
    .done       (done),
    .sb_req     (sb_req),
    .sb_masked  (sb_masked),
    .sb_data    (sb_data),
    .sb_mask_in (sb_mask_in),
    .sb_mask_out(sb_mask_out),
    .sb_rand    (sb_rand),
    .sb_ack     (sb_ack),
    .sb_result  (sb_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  int req_cnt, ack_cnt, busy_cnt, hold_bad, ndone;
  bit rand_lat = 0;
  int fix_lat  = 1;
  logic [7:0] log_mi [64];
  logic [7:0] log_mo [64];
  logic [7:0] log_r  [64];
  logic       log_m  [64];
  logic [7:0] ob [N];
  logic [7:0] om [N];
  vec_t       vecs [48];

  logic [7:0] s_lo [16] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
  logic [7:0] s_hi [16] = '{
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3)
             ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    req_cnt  = 0;
    ack_cnt  = 0;
    busy_cnt = 0;
    hold_bad = 0;
    ndone    = 0;
  endtask

  // S-box core model: acks after a programmable latency
  initial begin
    logic [7:0] c_d, c_mi, c_mo, c_r, c_res;
    logic       c_m;
    int         wcnt;
    core_ack = 1'b0;
    core_res = 8'h00;
    wcnt     = 0;
    forever begin
      @(negedge clk);
      core_ack = 1'b0;
      if (!rst_n) begin
        wcnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (wcnt > 0) begin
          if (sb_data !== c_d || sb_mask_in !== c_mi ||
              sb_mask_out !== c_mo || sb_rand !== c_r ||
              sb_masked !== c_m)
            hold_bad++;
          wcnt--;
          if (wcnt == 0) begin
            core_ack = 1'b1;
            core_res = c_res;
            ack_cnt++;
          end
        end
        if (sb_req) begin
          c_d  = sb_data;
          c_mi = sb_mask_in;
          c_mo = sb_mask_out;
          c_r  = sb_rand;
          c_m  = sb_masked;
          c_res = c_m ? (sbox(c_d ^ c_mi) ^ c_mo) : sbox(c_d);
          if (req_cnt < 64) begin
            log_mi[req_cnt] = c_mi;
            log_mo[req_cnt] = c_mo;
            log_r[req_cnt]  = c_r;
            log_m[req_cnt]  = c_m;
          end
          req_cnt++;
          wcnt = rand_lat ? int'($urandom_range(1, 5)) : fix_lat;
        end
      end
    end
  end

  task automatic feed(input int base, input bit msk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      int g = 0;
      in_valid  = 1'b1;
      in_byte   = vecs[base + i].in_b;
      in_mask   = vecs[base + i].in_m;
      masked_en = msk;
      #1;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        #1;
        g++;
      end
      if (g >= 50) chk("feed_timeout", g, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    masked_en = ~msk;
  endtask

  task automatic drain(input bit bp);
    int k = 0;
    int g = 0;
    bit stall = 0;
    logic [7:0] pb, pm;
    while (k < N && g < 800) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall && (out_byte !== pb || out_mask !== pm))
        hold_bad++;
      if (out_valid && out_ready) begin
        ob[k] = out_byte;
        om[k] = out_mask;
        if (done) ndone++;
        k++;
        stall = 0;
      end else begin
        stall = out_valid;
        pb    = out_byte;
        pm    = out_mask;
      end
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    chk("drain_count", k, N);
  endtask

  task automatic chk_true(input int base, input string nm);
    for (int i = 0; i < N; i++)
      chk(nm, ob[i] ^ om[i], vecs[base + i].exp_t);
  endtask

  initial begin
    logic [15:0] m;
    int g;
    for (int i = 0; i < 16; i++) begin
      vecs[i]      = '{8'(i), 8'h00, s_lo[i]};
      vecs[16 + i] = '{8'(i) ^ 8'h42, 8'h42, s_lo[i]};
      vecs[32 + i] = '{8'(16 + i), 8'h00, s_hi[i]};
    end
    rst_n     = 1'b0;
    masked_en = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_mask   = 8'h00;
    out_ready = 1'b0;
    spur_ack  = 1'b0;
    spur_res  = 8'h00;
    clr();

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy_done_req", {busy, done, sb_req}, 0);
    chk("rst_bytes", {out_byte, out_mask, sb_data, sb_rand}, 0);
    chk("rst_masks", {sb_mask_in, sb_mask_out, 7'd0, sb_masked}, 0);
    rst_n = 1'b1;
    #1;
    chk("fill_in_ready", in_ready, 1);

    // plain run, spurious acks in FILL and DRAIN
    @(negedge clk);
    spur_ack = 1'b1;
    spur_res = 8'h5a;
    @(negedge clk);
    spur_ack = 1'b0;
    #1;
    chk("spur_fill", {in_ready, busy}, 2'b10);
    clr();
    feed(0, 1'b0);
    g = 0;
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("plain_busy_cycles", busy_cnt, 32);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    #1;
    chk("spur_drain", {out_valid, busy, out_byte}, {2'b10, 8'h63});
    drain(1'b0);
    chk_true(0, "plain_out");
    for (int i = 0; i < N; i++) begin
      chk("plain_out_mask", om[i], 0);
      chk("plain_ops", {log_mi[i], log_mo[i], log_r[i],
                        7'd0, log_m[i]}, 0);
    end
    chk("plain_done", ndone, 1);
    chk("plain_reqs", req_cnt, N);
    chk("plain_hold", hold_bad, 0);

    // masked run with LFSR-derived output masks
    clr();
    feed(16, 1'b1);
    drain(1'b0);
    chk_true(16, "masked_out");
    m = 16'hACE1;
    for (int i = 0; i < N; i++) begin
      chk("masked_mask_in", log_mi[i], 8'h42);
      chk("masked_mask_out", log_mo[i], m[7:0]);
      chk("masked_rand", log_r[i], m[15:8]);
      chk("masked_flag", log_m[i], 1);
      chk("masked_out_mask", om[i], m[7:0]);
      m = lstep(m);
    end
    chk("masked_done", ndone, 1);

    // random ack latency and output backpressure
    clr();
    rand_lat = 1;
    feed(16, 1'b1);
    drain(1'b1);
    rand_lat = 0;
    chk_true(16, "bp_out");
    chk("bp_reqs", req_cnt, N);
    chk("bp_hold", hold_bad, 0);
    chk("bp_done", ndone, 1);
    chk("bp_mask_out0", log_mo[0], m[7:0]);

    // flush after five acks
    clr();
    feed(0, 1'b0);
    g = 0;
    while (ack_cnt < 5 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("flush_acks_seen", ack_cnt >= 5, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_state", {in_ready, busy, out_valid}, 3'b100);
    clr();
    feed(32, 1'b0);
    drain(1'b0);
    chk_true(32, "flush_new_out");
    chk("flush_done", ndone, 1);
    chk("flush_reqs", req_cnt, N);

    // async reset while waiting on the core
    clr();
    fix_lat = 3;
    feed(16, 1'b1);
    g = 0;
    while (!(busy && !sb_req) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("arst_in_wait", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {sb_req, busy, out_valid, in_ready}, 0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    fix_lat = 1;
    clr();
    feed(16, 1'b1);
    drain(1'b0);
    chk_true(16, "arst_out");
    chk("arst_lfsr_lo", log_mo[0], 8'hE1);
    chk("arst_lfsr_hi", log_r[0], 8'hAC);
    chk("arst_lfsr_next", log_mo[1], 8'(lstep(16'hACE1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subbytes_sched.md
# subbytes_sched

Sequencer that runs a 16-byte AES state through one shared Canright S-box core, one byte at a time, in plain or first-order masked mode. It buffers a full state from a byte-serial input stream, issues one S-box request per byte with fresh output mask and randomness from an internal LFSR, collects results, then streams the substituted state out. It sits between the top-level I/O command logic and the S-box core.

## Interface
- N_BYTES, 16, bytes per state (2..16)
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- masked_en  in  1  mode select, sampled on entry to RUN
- flush  in  1  synchronous abort to FILL, counters cleared
- in_valid / in_ready  in / out  1 / 1  input byte handshake
- in_byte, in_mask  in  8, 8  input share and its mask (true = in_byte ^ in_mask)
- out_valid / out_ready  out / in  1 / 1  output byte handshake
- out_byte, out_mask  out  8, 8  output share and mask (true = out_byte ^ out_mask)
- busy  out  1  high in RUN_REQ, RUN_WAIT
- done  out  1  one-cycle pulse when last output byte transfers
- sb_req  out  1  one-cycle S-box request
- sb_masked  out  1  masked-mode flag to core
- sb_data, sb_mask_in, sb_mask_out, sb_rand  out  8 each  core operands
- sb_ack  in  1  result valid strobe from core
- sb_result  in  8  core result (masked by sb_mask_out when sb_masked)

## Operation
- States: FILL, RUN_REQ, RUN_WAIT, DRAIN. Reset/flush -> FILL, idx = 0.
- FILL: in_ready = 1; each transfer writes {in_byte, in_mask} to buf[idx], idx++. Transfer at idx = N_BYTES-1 -> RUN_REQ, idx = 0, mode latched from masked_en.
- RUN_REQ: sb_req = 1 for exactly one cycle; drive sb_data = buf[idx].byte. Masked: sb_mask_in = buf[idx].mask, sb_mask_out = lfsr[7:0], sb_rand = lfsr[15:8], sb_masked = 1, LFSR advances. Plain: sb_data = byte ^ mask, all mask/rand outputs 0, sb_masked = 0, LFSR holds. Next -> RUN_WAIT. Operand outputs hold stable until ack.
- RUN_WAIT: on sb_ack, res[idx] = {sb_result, issued sb_mask_out}; idx++ ; if idx was N_BYTES-1 -> DRAIN, idx = 0, else RUN_REQ. sb_ack outside RUN_WAIT ignored.
- DRAIN: out_valid = 1, out_byte/out_mask = res[idx]; transfer advances idx; last transfer pulses done, -> FILL.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shift right, feedback mask 16'hB400.
- buf and res may share storage (write-back in place).

## Timing
- Reset values: in_ready 0 during reset then 1 in FILL; out_valid 0; busy 0; done 0; sb_req 0; all 8-bit outputs 0; lfsr = LFSR_SEED.
- Per byte in RUN: 1 cycle RUN_REQ + k cycles wait (k >= 1, ack latency). With 1-cycle ack: 2*N_BYTES cycles, 32 for 16 bytes.
- Input and output transfers happen only when valid & ready same cycle; out_byte/out_mask stable while out_valid & !out_ready.
- flush has priority over every transfer and sb_ack in the same cycle; an ack arriving after flush is ignored.
- Async reset mid-RUN: all state returns to reset values immediately; sb_req drops without waiting for ack.
- masked_en changes outside FILL->RUN_REQ edge have no effect on the current state.

## Test plan
- Plain: masked_en=0, feed bytes 0x00..0x0F with in_mask=0, core acks 1 cycle -> out_byte = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76, out_mask = 0, done once.
- Masked: masked_en=1, in_byte = i ^ 0x42, in_mask = 0x42, i = 0x00..0x0F -> out_byte ^ out_mask = S(i); sb_mask_out sequence equals LFSR from 16'hACE1 low bytes; sb_mask_in = 0x42 every request.
- Latency/backpressure: core ack delayed 1..5 cycles randomly, out_ready toggled 50% -> same results, sb_req exactly 16 pulses, outputs held while stalled.
- Spurious ack: sb_ack asserted in FILL and DRAIN -> no state change.
- Flush during RUN after 5 acks -> next cycle FILL, in_ready=1; new state of 0x10..0x1F yields ca 82 c9 7d fa 59 47 f0 ad d4 a2 af 9c a4 72 c0.
- Async reset in RUN_WAIT -> sb_req, busy, out_valid 0 before next edge; lfsr = 16'hACE1.
